pipe_hazard_ctrl: RTL

- Central stall/flush sequencer for the 5-stage MIPS pipeline (F, D, E, M, W).
- Computes the per-cycle write-enable and clear controls for the PC, D-stage, E-stage and M-stage pipeline registers from Tuse/Tnew hazard data.
- Owns the multi-cycle multiply/divide busy counter and its stall rule.
- Arbitrates stalls against CP0 interrupt/exception requests and the ERET/EPC dependency.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 11 +
 rtl/pipe_hazard_ctrl_mdu_busy_timer.sv | 37 +++
 rtl/pipe_hazard_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the MIPS pipeline hazard controller and the MDU datapath.
// The multiply/divide latencies are defined here so that both sides agree on them.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] TUSE_NONE    = 2'd3;
  localparam logic [4:0] EPC_IDX      = 5'd14;
  localparam int         MULT_CYC_DEF = 5;
  localparam int         DIV_CYC_DEF  = 10;
  localparam int         CNT_W_DEF    = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_mdu_busy_timer.sv
// Busy counter for the multi-cycle multiply/divide unit.
// A start loads the latency for the operation; the counter then runs down to zero.
module mdu_busy_timer
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic sel_div,
  output logic busy
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (reset) begin
      cnt_nxt = '0;
    end else if (start) begin
      // div wins when decode raises both start lines
      cnt_nxt = sel_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    end else if (cnt != '0) begin
      cnt_nxt = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt  <= cnt_nxt;
    busy <= (cnt_nxt != '0);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: Tuse/Tnew register hazards,
// MDU busy stalls, ERET/EPC ordering and CP0 request override.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic [4:0]  e_wa,
  input  logic [1:0]  e_tnew,
  input  logic [4:0]  m_wa,
  input  logic [1:0]  m_tnew,
  input  logic        d_is_md,
  input  logic        e_start_mult,
  input  logic        e_start_div,
  input  logic        d_is_eret,
  input  logic        e_mtc0_epc,
  input  logic        m_mtc0_epc,
  input  logic        req,
  output logic        pc_en,
  output logic        d_we,
  output logic        d_clr,
  output logic        e_we,
  output logic        e_clr,
  output logic        e_int,
  output logic        m_we,
  output logic        mdu_busy,
  output logic        mdu_start,
  output logic [31:0] stall_cnt
);

  function automatic logic src_hazard(input logic [4:0] idx, input logic [1:0] tuse,
                                      input logic [4:0] ewa, input logic [1:0] etn,
                                      input logic [4:0] mwa, input logic [1:0] mtn);
    // $0 never carries a dependency; TUSE_NONE can never be exceeded by a 2-bit Tnew
    if (idx == 5'd0 || tuse == TUSE_NONE) return 1'b0;
    return (ewa == idx && etn > tuse) || (mwa == idx && mtn > tuse);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic s_rs, s_rt, s_md, s_eret, stall;

  assign s_rs   = src_hazard(d_rs, d_tuse_rs, e_wa, e_tnew, m_wa, m_tnew);
  assign s_rt   = src_hazard(d_rt, d_tuse_rt, e_wa, e_tnew, m_wa, m_tnew);
  assign s_md   = d_is_md && (mdu_busy || e_start_mult || e_start_div);
  assign s_eret = d_is_eret && (e_mtc0_epc || m_mtc0_epc);

  // req always wins; reset forces the pipeline to free-run
  assign stall = (s_rs | s_rt | s_md | s_eret) & ~req & ~reset;

  assign pc_en     = ~stall;
  assign d_we      = ~stall;
  assign e_clr     = stall;
  assign e_we      = 1'b1;
  assign m_we      = 1'b1;
  assign e_int     = req;
  assign d_clr     = d_is_eret & ~stall & ~req & ~reset;
  assign mdu_start = (e_start_mult | e_start_div) & ~req & ~reset;

  mdu_busy_timer #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_busy_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (mdu_start),
    .sel_div (e_start_div),
    .busy    (mdu_busy)
  );

  always_ff @(posedge clk) begin
    if (reset)      stall_cnt <= '0;
    else if (stall) stall_cnt <= sat_inc(stall_cnt);
  end

  // decode never issues a new mult/div while the previous one is still running
  a_md_no_restart: assert property (@(posedge clk) disable iff (reset)
    !((e_start_mult || e_start_div) && mdu_busy));

endmodule
